// File: rtl/sccb_seq_pkg.sv
// Shared types and constants for the SCCB power-up sequencer.
package sccb_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    WR_REQ,
    RD_REQ,
    CHECK,
    RELEASE,
    DELAY,
    NEXT,
    H_REQ,
    H_ACK
  } state_t;

  // An address byte of FF marks a delay entry; FF/FF terminates the table.
  localparam logic [7:0]  MARK = 8'hFF;
  localparam logic [15:0] END  = 16'hFFFF;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } entry_t;

  // Clock cycles in one millisecond of XCLK.
  function automatic int CYC_PER_MS(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  // Error counter increment that sticks at 255.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Request/response bundle between the sequencer and the 2-wire SCCB master.
interface sccb_init_sequencer_if;
  logic       sccb_start;
  logic [7:0] sccb_ip_addr;
  logic [7:0] sccb_sub_addr;
  logic [7:0] sccb_data_in;
  logic [7:0] sccb_data_out;
  logic       sccb_done;

  // Sequencer side: issues requests, consumes completion and read data.
  modport master (
    output sccb_start, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    input  sccb_data_out, sccb_done
  );

  // SCCB master side.
  modport slave (
    input  sccb_start, sccb_ip_addr, sccb_sub_addr, sccb_data_in,
    output sccb_data_out, sccb_done
  );
endinterface

// File: rtl/sccb_cfg_rom.sv
// Camera power-up register table, ROM_DEPTH x {sub_addr, data}, synchronous read.
module sccb_cfg_rom
  import sccb_seq_pkg::*;
#(
  parameter int ROM_DEPTH = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output entry_t           q
);

  // Table contents; unused slots read as the end marker.
  function automatic entry_t table_entry(input int i);
    case (i)
      0:       return entry_t'(16'h1280);  // COM7: register reset
      1:       return entry_t'(16'h1101);  // CLKRC: prescaler
      2:       return entry_t'(16'hFF03);  // wait 3 ms for the sensor to settle
      3:       return entry_t'(16'h3A04);  // TSLB: output sequence
      default: return entry_t'(END);
    endcase
  endfunction

  entry_t rom_mem [ROM_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign rom_mem[gi] = table_entry(gi);
    end
  endgenerate

  // Registered read so the table maps onto block RAM.
  always_ff @(posedge clk) begin
    q <= rom_mem[addr];
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks the camera init table through the SCCB master, verifies each write by
// read-back, and arbitrates single-register host accesses onto the same master.
module sccb_init_sequencer
  import sccb_seq_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = 8'h42,
  parameter int         CLK_HZ      = 24_000_000,
  parameter int         ROM_DEPTH   = 64,
  parameter bit         VERIFY      = 1'b1,
  parameter int         TIMEOUT_CYC = 2_000_000
) (
  input  logic       XCLK,
  input  logic       RST,
  input  logic       init_go,
  output logic       init_busy,
  output logic       init_done,
  output logic       init_err,
  output logic [7:0] err_count,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       host_err,
  sccb_init_sequencer_if.master sccb
);

  localparam int               IDX_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);
  localparam logic [31:0]      CPM      = 32'(CYC_PER_MS(CLK_HZ));
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       DEV_RD   = DEV_ID | 8'h01;

  state_t           state_reg, state_next;
  state_t           ret_reg, ret_next;
  logic [IDX_W-1:0] idx_reg;
  logic             walk_reg, done_reg, err_reg;
  logic [7:0]       err_cnt_reg;
  logic [31:0]      to_cnt_reg, dly_cnt_reg;
  logic [7:0]       rd_data_reg, host_rdata_reg;
  logic             host_we_reg, herr_reg;
  logic             start_reg;
  logic [7:0]       ip_reg, sub_reg, din_reg;
  entry_t           rom_q;
  logic             is_req, timed_out, last_idx;

  sccb_cfg_rom #(.ROM_DEPTH(ROM_DEPTH), .IDX_W(IDX_W)) u_rom (
    .clk  (XCLK),
    .addr (idx_reg),
    .q    (rom_q)
  );

  assign is_req    = (state_reg inside {WR_REQ, RD_REQ, H_REQ});
  assign timed_out = is_req && !sccb.sccb_done && (to_cnt_reg == TO_LAST);
  assign last_idx  = (idx_reg == LAST_IDX);

  // State register, including where RELEASE hands control back to.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      state_reg <= IDLE;
      ret_reg   <= IDLE;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
    end
  end

  // Next-state logic; completion beats timeout when both land together.
  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    case (state_reg)
      IDLE: begin
        if (init_go)       state_next = FETCH;
        else if (host_req) state_next = H_REQ;
      end
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (rom_q == END)            state_next = IDLE;
        else if (rom_q.addr == MARK) state_next = DELAY;
        else                         state_next = WR_REQ;
      end
      WR_REQ: begin
        if (sccb.sccb_done) begin
          state_next = RELEASE;
          ret_next   = VERIFY ? RD_REQ : NEXT;
        end else if (timed_out) begin
          state_next = RELEASE;
          ret_next   = NEXT;
        end
      end
      RD_REQ: begin
        if (sccb.sccb_done) begin
          state_next = RELEASE;
          ret_next   = CHECK;
        end else if (timed_out) begin
          state_next = RELEASE;
          ret_next   = NEXT;
        end
      end
      CHECK:   state_next = NEXT;
      RELEASE: if (!sccb.sccb_done) state_next = ret_reg;
      DELAY:   if (dly_cnt_reg == 32'd0) state_next = NEXT;
      NEXT:    state_next = last_idx ? IDLE : FETCH;
      H_REQ: begin
        if (sccb.sccb_done || timed_out) begin
          state_next = RELEASE;
          ret_next   = H_ACK;
        end
      end
      H_ACK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Walk bookkeeping: index, status flags, error count, delay and timeout counters.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      idx_reg        <= '0;
      walk_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_cnt_reg    <= 8'd0;
      to_cnt_reg     <= 32'd0;
      dly_cnt_reg    <= 32'd0;
      rd_data_reg    <= 8'd0;
      host_rdata_reg <= 8'd0;
      host_we_reg    <= 1'b0;
      herr_reg       <= 1'b0;
    end else begin
      // Restarts on every entry into a request state.
      to_cnt_reg <= (is_req && state_next == state_reg) ? to_cnt_reg + 32'd1 : 32'd0;
      case (state_reg)
        IDLE: begin
          if (init_go) begin
            idx_reg     <= '0;
            walk_reg    <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 8'd0;
          end else if (host_req) begin
            host_we_reg <= host_we;
            herr_reg    <= 1'b0;
          end
        end
        DECODE: begin
          if (rom_q == END) begin
            done_reg <= 1'b1;
            walk_reg <= 1'b0;
          end else if (rom_q.addr == MARK) begin
            dly_cnt_reg <= 32'(rom_q.data) * CPM;
          end
        end
        WR_REQ: begin
          if (timed_out) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
            err_reg     <= 1'b1;
          end
        end
        RD_REQ: begin
          if (sccb.sccb_done) begin
            rd_data_reg <= sccb.sccb_data_out;
          end else if (timed_out) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
            err_reg     <= 1'b1;
          end
        end
        CHECK: begin
          if (rd_data_reg != rom_q.data) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
            err_reg     <= 1'b1;
          end
        end
        DELAY: begin
          if (dly_cnt_reg != 32'd0) dly_cnt_reg <= dly_cnt_reg - 32'd1;
        end
        NEXT: begin
          if (last_idx) begin
            done_reg <= 1'b1;
            walk_reg <= 1'b0;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        H_REQ: begin
          if (sccb.sccb_done) begin
            if (!host_we_reg) host_rdata_reg <= sccb.sccb_data_out;
          end else if (timed_out) begin
            herr_reg    <= 1'b1;
            err_cnt_reg <= sat_inc(err_cnt_reg);
          end
        end
        default: ;
      endcase
    end
  end

  // Request registers: loaded on entry to a request state, frozen while start is high.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      start_reg <= 1'b0;
      ip_reg    <= DEV_ID;
      sub_reg   <= 8'd0;
      din_reg   <= 8'd0;
    end else begin
      start_reg <= (state_next inside {WR_REQ, RD_REQ, H_REQ});
      if (state_reg == DECODE && state_next == WR_REQ) begin
        ip_reg  <= DEV_ID;
        sub_reg <= rom_q.addr;
        din_reg <= rom_q.data;
      end
      if (state_reg == RELEASE && state_next == RD_REQ) begin
        ip_reg <= DEV_RD;
      end
      if (state_reg == IDLE && state_next == H_REQ) begin
        ip_reg  <= host_we ? DEV_ID : DEV_RD;
        sub_reg <= host_addr;
        if (host_we) din_reg <= host_wdata;
      end
    end
  end

  // Output decode.
  always_comb begin
    init_busy          = walk_reg;
    init_done          = done_reg;
    init_err           = err_reg;
    err_count          = err_cnt_reg;
    host_ack           = (state_reg == H_ACK);
    host_err           = (state_reg == H_ACK) && herr_reg;
    host_rdata         = host_rdata_reg;
    sccb.sccb_start    = start_reg;
    sccb.sccb_ip_addr  = ip_reg;
    sccb.sccb_sub_addr = sub_reg;
    sccb.sccb_data_in  = din_reg;
  end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: behavioural SCCB master plus a transaction scoreboard.
module tb_sccb_init_sequencer;

  logic       XCLK = 1'b0;
  logic       RST = 1'b1;
  logic       init_go = 1'b0;
  logic       init_busy, init_done, init_err;
  logic [7:0] err_count;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_wdata = 8'd0;
  logic       host_ack, host_err;
  logic [7:0] host_rdata;

  int checks = 0;
  int errors = 0;

  always #5 XCLK = ~XCLK;

  sccb_init_sequencer_if sif ();

  sccb_init_sequencer #(
    .DEV_ID(8'h42), .CLK_HZ(1000), .ROM_DEPTH(64), .VERIFY(1'b1), .TIMEOUT_CYC(100)
  ) dut (
    .XCLK(XCLK), .RST(RST), .init_go(init_go), .init_busy(init_busy),
    .init_done(init_done), .init_err(init_err), .err_count(err_count),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_err(host_err), .sccb(sif)
  );

  typedef struct packed {
    logic [7:0] ip;
    logic [7:0] sub;
    logic [7:0] din;
  } txn_t;

  txn_t       exp_q[$];
  txn_t       obs_q[$];
  logic [7:0] exp_rd_q[$];

  // SCCB master model: 3-cycle transactions, done held until start falls.
  logic [7:0] mem [256];
  bit         m_hang = 1'b0;
  bit         m_bad11 = 1'b0;
  logic       m_active = 1'b0;
  int         m_cnt = 0;

  always @(posedge XCLK) begin
    if (RST) begin
      sif.sccb_done     <= 1'b0;
      sif.sccb_data_out <= 8'd0;
      m_active          <= 1'b0;
      m_cnt             <= 0;
    end else if (sif.sccb_done) begin
      if (!sif.sccb_start) sif.sccb_done <= 1'b0;
    end else if (m_active) begin
      if (!sif.sccb_start) begin
        m_active <= 1'b0;
      end else if (!m_hang) begin
        if (m_cnt == 2) begin
          sif.sccb_done <= 1'b1;
          m_active      <= 1'b0;
          if (sif.sccb_ip_addr[0])
            sif.sccb_data_out <= (m_bad11 && sif.sccb_sub_addr == 8'h11) ? 8'h00 : mem[sif.sccb_sub_addr];
          else
            mem[sif.sccb_sub_addr] <= sif.sccb_data_in;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (sif.sccb_start) begin
      m_active <= 1'b1;
      m_cnt    <= 0;
      obs_q.push_back({sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in});
      $display("txn ip=%h sub=%h data=%h", sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in);
    end
  end

  // Request fields must not move while start is held.
  int         stab_err = 0;
  logic       prev_start = 1'b0;
  logic [23:0] prev_bus = 24'd0;
  always @(posedge XCLK) begin
    if (sif.sccb_start && prev_start &&
        {sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in} != prev_bus)
      stab_err <= stab_err + 1;
    prev_start <= sif.sccb_start;
    prev_bus   <= {sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in};
  end

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  task automatic pulse_init();
    init_go = 1'b1;
    tick();
    init_go = 1'b0;
  endtask

  task automatic push_walk(input bit with_reads);
    exp_q.push_back({8'h42, 8'h12, 8'h80});
    if (with_reads) exp_q.push_back({8'h43, 8'h12, 8'h00});
    exp_q.push_back({8'h42, 8'h11, 8'h01});
    if (with_reads) exp_q.push_back({8'h43, 8'h11, 8'h00});
    exp_q.push_back({8'h42, 8'h3A, 8'h04});
    if (with_reads) exp_q.push_back({8'h43, 8'h3A, 8'h00});
  endtask

  task automatic wait_walk(output int dly, output bit ok);
    ok = 1'b0;
    dly = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!init_busy) begin
        ok = 1'b1;
        break;
      end
      if (dut.state_reg == sccb_seq_pkg::DELAY) dly++;
      tick();
    end
  endtask

  task automatic do_host(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                         output bit ok, output logic [7:0] rd, output logic er);
    host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    ok = 1'b0; rd = 8'hxx; er = 1'bx;
    for (int i = 0; i < 1500; i++) begin
      tick();
      if (host_ack) begin
        ok = 1'b1; rd = host_rdata; er = host_err;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    checks++; if (sif.sccb_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b want 0", sif.sccb_start); end
    checks++; if (sif.sccb_ip_addr !== 8'h42) begin errors++; $display("FAIL rst_ip got %h want 42", sif.sccb_ip_addr); end
    checks++; if (sif.sccb_sub_addr !== 8'h00 || sif.sccb_data_in !== 8'h00) begin errors++; $display("FAIL rst_sub_din got %h/%h want 00/00", sif.sccb_sub_addr, sif.sccb_data_in); end
    checks++; if ({init_busy, init_done, init_err} !== 3'b000) begin errors++; $display("FAIL rst_init_flags got %b want 000", {init_busy, init_done, init_err}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d want 0", err_count); end
    checks++; if ({host_ack, host_err} !== 2'b00 || host_rdata !== 8'h00) begin errors++; $display("FAIL rst_host got ack=%b err=%b rdata=%h want 0/0/00", host_ack, host_err, host_rdata); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_echo_walk();
    int dly; bit ok; txn_t o, e;
    m_hang = 1'b0; m_bad11 = 1'b0;
    obs_q.delete(); exp_q.delete();
    push_walk(1'b1);
    pulse_init();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL go_busy_t1 got %b want 1", init_busy); end
    tick();
    checks++; if (sif.sccb_start !== 1'b0) begin errors++; $display("FAIL go_start_t2 got %b want 0", sif.sccb_start); end
    tick();
    checks++; if (sif.sccb_start !== 1'b1) begin errors++; $display("FAIL go_start_t3 got %b want 1", sif.sccb_start); end
    wait_walk(dly, ok);
    checks++; if (!ok) begin errors++; $display("FAIL walk_end got busy=%b want 0", init_busy); end
    checks++; if (dly < 2 || dly > 4) begin errors++; $display("FAIL delay_cycles got %0d want 3+-1", dly); end
    checks++; if ({init_done, init_err} !== 2'b10 || err_count !== 8'd0) begin errors++; $display("FAIL walk_status got done=%b err=%b cnt=%0d want 1/0/0", init_done, init_err, err_count); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL walk_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || (!e.ip[0] && o.din !== e.din)) begin errors++; $display("FAIL walk_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL walk_missing got %0d left want 0", exp_q.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL req_stable got %0d changes want 0", stab_err); end
  endtask

  task automatic test_mismatch();
    int dly; bit ok; txn_t o, e;
    m_bad11 = 1'b1;
    obs_q.delete(); exp_q.delete();
    push_walk(1'b1);
    pulse_init();
    wait_walk(dly, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mis_end got busy=%b want 0", init_busy); end
    checks++; if ({init_done, init_err} !== 2'b11 || err_count !== 8'd1) begin errors++; $display("FAIL mis_status got done=%b err=%b cnt=%0d want 1/1/1", init_done, init_err, err_count); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL mis_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || (!e.ip[0] && o.din !== e.din)) begin errors++; $display("FAIL mis_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mis_missing got %0d left want 0", exp_q.size()); end
    m_bad11 = 1'b0;
  endtask

  task automatic test_timeout();
    int dly, hi; bit ok; txn_t o, e;
    m_hang = 1'b1;
    obs_q.delete(); exp_q.delete();
    push_walk(1'b0);
    pulse_init();
    for (int i = 0; i < 10 && !sif.sccb_start; i++) tick();
    hi = 0;
    for (int i = 0; i < 300 && sif.sccb_start; i++) begin hi++; tick(); end
    checks++; if (hi != 100) begin errors++; $display("FAIL to_start_cycles got %0d want 100", hi); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL to_first_count got %0d want 1", err_count); end
    wait_walk(dly, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_end got busy=%b want 0", init_busy); end
    checks++; if ({init_done, init_err} !== 2'b11 || err_count !== 8'd3) begin errors++; $display("FAIL to_status got done=%b err=%b cnt=%0d want 1/1/3", init_done, init_err, err_count); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL to_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || o.din !== e.din) begin errors++; $display("FAIL to_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL to_missing got %0d left want 0", exp_q.size()); end
    m_hang = 1'b0;
  endtask

  task automatic test_host();
    bit ok; logic [7:0] rd; logic er; txn_t o, e;
    obs_q.delete(); exp_q.delete(); exp_rd_q.delete();
    exp_q.push_back({8'h42, 8'h0A, 8'h76});
    do_host(1'b1, 8'h0A, 8'h76, ok, rd, er);
    checks++; if (!ok || er !== 1'b0) begin errors++; $display("FAIL hwr_ack got ok=%b err=%b want 1/0", ok, er); end
    tick();
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL hwr_ack_pulse got %b want 0", host_ack); end
    exp_q.push_back({8'h43, 8'h0A, 8'h00});
    exp_rd_q.push_back(8'h76);
    do_host(1'b0, 8'h0A, 8'h00, ok, rd, er);
    checks++; if (!ok || rd !== exp_rd_q.pop_front() || er !== 1'b0) begin errors++; $display("FAIL hrd_data got ok=%b rdata=%h err=%b want 1/76/0", ok, rd, er); end
    tick();
    checks++; if (host_ack !== 1'b0 || host_rdata !== 8'h76) begin errors++; $display("FAIL hrd_pulse_hold got ack=%b rdata=%h want 0/76", host_ack, host_rdata); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL host_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || (!e.ip[0] && o.din !== e.din)) begin errors++; $display("FAIL host_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL host_missing got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_host_timeout();
    bit ok; logic [7:0] rd; logic er;
    m_hang = 1'b1;
    do_host(1'b0, 8'h0C, 8'h00, ok, rd, er);
    checks++; if (!ok || er !== 1'b1) begin errors++; $display("FAIL hto_err got ok=%b err=%b want 1/1", ok, er); end
    tick();
    checks++; if (host_ack !== 1'b0 || host_err !== 1'b0) begin errors++; $display("FAIL hto_pulse got ack=%b err=%b want 0/0", host_ack, host_err); end
    m_hang = 1'b0;
  endtask

  task automatic test_holdoff();
    bit ok; logic [7:0] rd; txn_t o, e;
    obs_q.delete(); exp_q.delete(); exp_rd_q.delete();
    push_walk(1'b1);
    exp_q.push_back({8'h43, 8'h12, 8'h00});
    exp_rd_q.push_back(8'h80);
    host_we = 1'b0; host_addr = 8'h12; host_req = 1'b1; init_go = 1'b1;
    tick();
    init_go = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (host_ack) begin ok = 1'b1; break; end
    end
    rd = host_rdata;
    checks++; if (!ok || init_done !== 1'b1 || init_busy !== 1'b0) begin errors++; $display("FAIL hold_order got ok=%b done=%b busy=%b want 1/1/0", ok, init_done, init_busy); end
    checks++; if (rd !== exp_rd_q.pop_front() || host_err !== 1'b0) begin errors++; $display("FAIL hold_rdata got %h err=%b want 80/0", rd, host_err); end
    host_req = 1'b0;
    tick();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL hold_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || (!e.ip[0] && o.din !== e.din)) begin errors++; $display("FAIL hold_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL hold_missing got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_rst_mid();
    int dly; bit ok; txn_t o, e;
    m_bad11 = 1'b1;
    pulse_init();
    for (int i = 0; i < 10 && !sif.sccb_start; i++) tick();
    for (int i = 0; i < 2; i++) tick();
    checks++; if (sif.sccb_start !== 1'b1) begin errors++; $display("FAIL mid_pre_start got %b want 1", sif.sccb_start); end
    RST = 1'b1;
    tick();
    checks++; if (sif.sccb_start !== 1'b0 || sif.sccb_ip_addr !== 8'h42 || sif.sccb_sub_addr !== 8'h00 || sif.sccb_data_in !== 8'h00) begin errors++; $display("FAIL mid_bus got %b/%h/%h/%h want 0/42/00/00", sif.sccb_start, sif.sccb_ip_addr, sif.sccb_sub_addr, sif.sccb_data_in); end
    checks++; if ({init_busy, init_done, init_err, host_ack} !== 4'b0000 || err_count !== 8'd0) begin errors++; $display("FAIL mid_status got %b cnt=%0d want 0000/0", {init_busy, init_done, init_err, host_ack}, err_count); end
    RST = 1'b0;
    m_bad11 = 1'b0;
    tick();
    obs_q.delete(); exp_q.delete();
    push_walk(1'b1);
    pulse_init();
    wait_walk(dly, ok);
    checks++; if (!ok || {init_done, init_err} !== 2'b10 || err_count !== 8'd0) begin errors++; $display("FAIL mid_rewalk got ok=%b done=%b err=%b cnt=%0d want 1/1/0/0", ok, init_done, init_err, err_count); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL mid_txn got ip=%h sub=%h want none", o.ip, o.sub); end
      else begin
        e = exp_q.pop_front();
        if (o.ip !== e.ip || o.sub !== e.sub || (!e.ip[0] && o.din !== e.din)) begin errors++; $display("FAIL mid_txn got %h/%h/%h want %h/%h/%h", o.ip, o.sub, o.din, e.ip, e.sub, e.din); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_missing got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_echo_walk();
    test_mismatch();
    test_timeout();
    test_host();
    test_host_timeout();
    test_holdoff();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
